// File: rtl/dma_mmio_ctrl_if.sv
// ---------------------------------------------------------------------------
// dma_mmio_ctrl_if
// Bus bundle for the DMA controller. It carries two buses and the interrupt:
//   - MMIO responder bus (CPU -> DMA register window):
//       dma_mmio_req/we/addr/wdata in, dma_mmio_rdata/ready out
//   - Memory initiator bus (DMA -> memory):
//       dma_mem_req/we/addr/wdata out, dma_mem_rdata/ready in
//   - dma_irq: level interrupt out
// Modports:
//   slave  : the DMA controller's view (responds on MMIO, initiates on memory)
//   master : the surrounding system's view (CPU/interconnect plus memory)
// ---------------------------------------------------------------------------
interface dma_mmio_ctrl_if #(
    parameter int XLEN = 32
);
    logic            dma_mmio_req;
    logic            dma_mmio_we;
    logic [XLEN-1:0] dma_mmio_addr;
    logic [XLEN-1:0] dma_mmio_wdata;
    logic [XLEN-1:0] dma_mmio_rdata;
    logic            dma_mmio_ready;

    logic            dma_mem_req;
    logic            dma_mem_we;
    logic [XLEN-1:0] dma_mem_addr;
    logic [XLEN-1:0] dma_mem_wdata;
    logic [XLEN-1:0] dma_mem_rdata;
    logic            dma_mem_ready;

    logic            dma_irq;

    modport slave (
        input  dma_mmio_req, dma_mmio_we, dma_mmio_addr, dma_mmio_wdata,
        output dma_mmio_rdata, dma_mmio_ready,
        output dma_mem_req, dma_mem_we, dma_mem_addr, dma_mem_wdata,
        input  dma_mem_rdata, dma_mem_ready,
        output dma_irq
    );

    modport master (
        output dma_mmio_req, dma_mmio_we, dma_mmio_addr, dma_mmio_wdata,
        input  dma_mmio_rdata, dma_mmio_ready,
        input  dma_mem_req, dma_mem_we, dma_mem_addr, dma_mem_wdata,
        output dma_mem_rdata, dma_mem_ready,
        input  dma_irq
    );
endinterface

// File: rtl/dma_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// dma_mmio_ctrl
// Word-by-word memory-to-memory DMA engine with an MMIO register window.
// Software programs SRC/DST/LEN, sets CTRL.START, then polls STATUS.DONE or
// waits for the interrupt.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   bus    dma_mmio_ctrl_if.slave
//            MMIO responder : dma_mmio_req/we/addr/wdata -> dma_mmio_rdata/ready
//            Mem initiator  : dma_mem_req/we/addr/wdata  <- dma_mem_rdata/ready
//            dma_irq        : level interrupt
//
// Register map (addr[4:2]):
//   0 SRC   1 DST   2 LEN (bytes)   3 CTRL {IE, START}   4 STATUS {DONE, BUSY}
//   5..7 read as zero, writes ignored.
//
// Build option:
//   DMA_IRQ_EN  when defined, CTRL.IE is implemented and
//               dma_irq = STATUS.DONE & CTRL.IE. When undefined, IE reads 0
//               and dma_irq is tied low.
// ---------------------------------------------------------------------------
module dma_mmio_ctrl #(
    parameter int XLEN  = 32,
    parameter int LEN_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    dma_mmio_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD2WR,
        S_WR,
        S_WR2RD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [XLEN-1:0]  r_src;
    logic [XLEN-1:0]  r_dst;
    logic [LEN_W-1:0] r_len;
    logic             r_done;
    logic             r_mmio_ready;

    logic [XLEN-1:0]  r_cur_src;
    logic [XLEN-1:0]  r_cur_dst;
    logic [LEN_W-1:0] r_remaining;
    logic [XLEN-1:0]  r_buf;

    logic             w_ie;
    logic             w_busy;
    logic             w_wr_en;
    logic             w_start;
    logic [2:0]       w_sel;
    logic [XLEN-1:0]  w_rd_val;
    logic [LEN_W-1:0] w_remaining_dec;

    logic             w_mem_req;
    logic             w_mem_we;
    logic [XLEN-1:0]  w_mem_addr;
    logic [XLEN-1:0]  w_mem_wdata;

    logic             w_unused_ok;

    assign w_busy          = (r_state != S_IDLE);
    assign w_sel           = bus.dma_mmio_addr[4:2];
    // A write takes effect in the single cycle the ready pulse is high.
    assign w_wr_en         = r_mmio_ready & bus.dma_mmio_req & bus.dma_mmio_we;
    assign w_start         = w_wr_en & (w_sel == 3'd3) & bus.dma_mmio_wdata[0] & ~w_busy;
    assign w_remaining_dec = r_remaining - LEN_W'(4);

    assign w_unused_ok = &{1'b0, bus.dma_mmio_addr[XLEN-1:5], bus.dma_mmio_addr[1:0]};

    // MMIO handshake: ready pulses the cycle after req is seen, and the
    // self-masking term forces at least one idle cycle between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mmio_ready <= 1'b0;
        end else begin
            r_mmio_ready <= bus.dma_mmio_req & ~r_mmio_ready;
        end
    end

    // Transfer parameters are frozen while a copy is in flight so the
    // running transfer always uses what was programmed at START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src <= '0;
            r_dst <= '0;
            r_len <= '0;
        end else if (w_wr_en && !w_busy) begin
            case (w_sel)
                3'd0:    r_src <= {bus.dma_mmio_wdata[XLEN-1:2], 2'b00};
                3'd1:    r_dst <= {bus.dma_mmio_wdata[XLEN-1:2], 2'b00};
                3'd2:    r_len <= {bus.dma_mmio_wdata[LEN_W-1:2], 2'b00};
                default: ;
            endcase
        end
    end

`ifdef DMA_IRQ_EN
    logic r_ie;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie <= 1'b0;
        end else if (w_wr_en && (w_sel == 3'd3)) begin
            r_ie <= bus.dma_mmio_wdata[1];
        end
    end

    assign w_ie        = r_ie;
    assign bus.dma_irq = r_done & r_ie;
`else
    assign w_ie        = 1'b0;
    assign bus.dma_irq = 1'b0;
`endif

    // DONE is set by the FSM and cleared by writing 1; the set has priority
    // so a completion racing a software clear is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_done <= 1'b1;
        end else if (w_wr_en && (w_sel == 3'd4) && bus.dma_mmio_wdata[1]) begin
            r_done <= 1'b0;
        end
    end

    // FSM state register plus the copy datapath (working pointers, byte
    // counter and the single-word holding buffer).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cur_src   <= '0;
            r_cur_dst   <= '0;
            r_remaining <= '0;
            r_buf       <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cur_src   <= r_src;
                        r_cur_dst   <= r_dst;
                        r_remaining <= r_len;
                    end
                end
                S_RD: begin
                    if (bus.dma_mem_ready) begin
                        r_buf <= bus.dma_mem_rdata;
                    end
                end
                S_WR: begin
                    if (bus.dma_mem_ready) begin
                        r_cur_src   <= r_cur_src + XLEN'(4);
                        r_cur_dst   <= r_cur_dst + XLEN'(4);
                        r_remaining <= w_remaining_dec;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic. The *2* states are the one-cycle request gaps
    // between consecutive memory transactions.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = (r_len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (bus.dma_mem_ready) begin
                    w_state_next = S_RD2WR;
                end
            end
            S_RD2WR: w_state_next = S_WR;
            S_WR: begin
                if (bus.dma_mem_ready) begin
                    w_state_next = (w_remaining_dec == '0) ? S_DONE : S_WR2RD;
                end
            end
            S_WR2RD: w_state_next = S_RD;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Memory outputs decode purely from registered state, so they are stable
    // for the whole request and fall immediately on asynchronous reset.
    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (r_state)
            S_RD: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_cur_src;
            end
            S_WR: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = r_cur_dst;
                w_mem_wdata = r_buf;
            end
            default: ;
        endcase
    end

    assign bus.dma_mem_req   = w_mem_req;
    assign bus.dma_mem_we    = w_mem_we;
    assign bus.dma_mem_addr  = w_mem_addr;
    assign bus.dma_mem_wdata = w_mem_wdata;

    // Register readback; START is a pulse and always reads 0.
    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            3'd0:    w_rd_val = r_src;
            3'd1:    w_rd_val = r_dst;
            3'd2:    w_rd_val = XLEN'(r_len);
            3'd3:    w_rd_val = XLEN'({w_ie, 1'b0});
            3'd4:    w_rd_val = XLEN'({r_done, w_busy});
            default: w_rd_val = '0;
        endcase
    end

    assign bus.dma_mmio_ready = r_mmio_ready;
    assign bus.dma_mmio_rdata = r_mmio_ready ? w_rd_val : '0;

endmodule
